// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: sink-side VGA geometry, lock and checksum checker.
// Define VGA_MON_CHECKSUM_EN to build the per-frame colour checksum.
module vga_frame_monitor #(
  parameter int EXP_H_TOTAL  = 800,
  parameter int EXP_H_ACTIVE = 640,
  parameter int EXP_V_TOTAL  = 525,
  parameter int EXP_V_ACTIVE = 480,
  parameter int TIMEOUT      = 4095
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        pixel_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blanking,
  input  logic [7:0]  colores,
  output logic [10:0] h_total,
  output logic [10:0] h_active,
  output logic [9:0]  v_total,
  output logic [9:0]  v_active,
  output logic [15:0] frame_sum,
  output logic        frame_done,
  output logic        locked,
  output logic        timing_err
);

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } state_t;

  localparam logic [10:0] HMAX = 11'd2047;
  localparam logic [9:0]  VMAX = 10'd1023;
  localparam logic [10:0] EHT  = 11'(EXP_H_TOTAL);
  localparam logic [10:0] EHA  = 11'(EXP_H_ACTIVE);
  localparam logic [9:0]  EVT  = 10'(EXP_V_TOTAL);
  localparam logic [9:0]  EVA  = 10'(EXP_V_ACTIVE);
  localparam logic [31:0] TLIM = 32'(TIMEOUT - 1);

  logic        s_hsync;
  logic        s_vsync;
  logic        s_blank;
  logic        s_en;
  logic        p_hsync;
  logic        p_vsync;
  logic [10:0] hcnt;
  logic [10:0] hact;
  logic [9:0]  vcnt;
  logic [9:0]  vact;
  logic        line_act;
  state_t      state;
  state_t      state_n;
  logic [1:0]  mcnt;
  logic [1:0]  mcnt_n;
  logic        done_n;
  logic        err_n;
  logic        hedge;
  logic        vedge;
  logic        active;
  logic        timeout;
  logic        bad_line;
  logic        match;
  logic [10:0] h_total_n;
  logic [10:0] h_active_n;
  logic [9:0]  v_active_n;

  // input sampling stage, every clock
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_hsync <= 1'b0;
      s_vsync <= 1'b0;
      s_blank <= 1'b0;
      s_en    <= 1'b0;
    end else begin
      s_hsync <= hsync;
      s_vsync <= vsync;
      s_blank <= blanking;
      s_en    <= pixel_en;
    end
  end

  assign hedge    = s_en & p_hsync & ~s_hsync;
  assign vedge    = s_en & p_vsync & ~s_vsync;
  assign active   = ~s_blank;
  assign timeout  = s_en & ~hedge & (hcnt != HMAX)
                  & ({21'd0, hcnt} == TLIM);
  assign bad_line = hedge & (hcnt != EHT);

  // values that a frame close at this tick would latch
  assign h_total_n  = hedge ? hcnt : h_total;
  assign h_active_n = hedge ? hact : h_active;
  assign v_active_n = vact + {9'd0, hedge & line_act};
  assign match = (h_total_n == EHT) & (h_active_n == EHA)
               & (vcnt == EVT) & (v_active_n == EVA);

  // line and frame geometry counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_hsync  <= 1'b1;
      p_vsync  <= 1'b1;
      hcnt     <= '0;
      hact     <= '0;
      vcnt     <= '0;
      vact     <= '0;
      line_act <= 1'b0;
      h_total  <= '0;
      h_active <= '0;
      v_total  <= '0;
      v_active <= '0;
    end else if (s_en) begin
      p_hsync <= s_hsync;
      p_vsync <= s_vsync;
      if (hedge) begin
        h_total  <= hcnt;
        h_active <= hact;
        hcnt     <= 11'd1;
        hact     <= {10'd0, active};
        line_act <= active;
        if (vcnt != VMAX) vcnt <= vcnt + 10'd1;
        if (line_act && vact != VMAX) vact <= vact + 10'd1;
      end else begin
        if (hcnt != HMAX) hcnt <= hcnt + 11'd1;
        if (active && hact != HMAX) hact <= hact + 11'd1;
        if (active) line_act <= 1'b1;
      end
      if (vedge) begin
        v_total  <= vcnt;
        v_active <= v_active_n;
        vcnt     <= {9'd0, hedge};
        vact     <= '0;
      end
    end
  end

`ifdef VGA_MON_CHECKSUM_EN
  logic [7:0]  s_col;
  logic [15:0] sum;

  // per-frame colour checksum, modulo 2^16
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_col     <= '0;
      sum       <= '0;
      frame_sum <= '0;
    end else begin
      s_col <= colores;
      if (s_en && vedge) begin
        frame_sum <= sum;
        sum       <= active ? {8'd0, s_col} : 16'd0;
      end else if (s_en && active) begin
        sum <= sum + {8'd0, s_col};
      end
    end
  end
`else
  logic unused_col;
  assign unused_col = ^colores;
  assign frame_sum  = 16'd0;
`endif

  // lock FSM state and registered pulses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SEARCH;
      mcnt       <= '0;
      frame_done <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      state      <= state_n;
      mcnt       <= mcnt_n;
      frame_done <= done_n;
      timing_err <= err_n;
    end
  end

  // lock FSM next state
  always_comb begin
    state_n = state;
    mcnt_n  = mcnt;
    if (timeout) begin
      state_n = SEARCH;
      mcnt_n  = 2'd0;
    end else begin
      unique case (state)
        SEARCH: begin
          if (vedge) begin
            state_n = MEASURE;
            mcnt_n  = 2'd0;
          end
        end
        MEASURE: begin
          if (vedge && match) begin
            mcnt_n = mcnt + 2'd1;
            if (mcnt == 2'd1) state_n = LOCKED;
          end else if (vedge) begin
            mcnt_n = 2'd0;
          end
        end
        LOCKED: begin
          if (bad_line || (vedge && !match)) begin
            state_n = MEASURE;
            mcnt_n  = 2'd0;
          end
        end
        default: begin
          state_n = SEARCH;
          mcnt_n  = 2'd0;
        end
      endcase
    end
  end

  // lock FSM outputs
  always_comb begin
    locked = (state == LOCKED);
    done_n = vedge & ~timeout & (state != SEARCH);
    err_n  = timeout
           | ((state == MEASURE) & vedge & ~match)
           | ((state == LOCKED) & (bad_line | (vedge & ~match)));
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb_vga_frame_monitor: random VGA frames vs a timestamp-based model.
// Expected pulses are queued per event and popped by a monitor.
module tb_vga_frame_monitor;

  localparam int H  = 10;
  localparam int HA = 6;
  localparam int V  = 5;
  localparam int VA = 3;
  localparam int TO = 30;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        pixel_en = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        blanking = 1'b1;
  logic [7:0]  colores = 8'd0;
  logic [10:0] h_total;
  logic [10:0] h_active;
  logic [9:0]  v_total;
  logic [9:0]  v_active;
  logic [15:0] frame_sum;
  logic        frame_done;
  logic        locked;
  logic        timing_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       hs;
    logic       vs;
    logic       bl;
    logic [7:0] col;
  } tick_t;

  typedef struct {
    bit done;
    bit err;
    bit lk;
    int ht;
    int ha;
    int vt;
    int va;
    int fs;
  } exp_t;

  tick_t stim[$];
  exp_t  sbq[$];
  bit    model_lk;

  vga_frame_monitor #(
    .EXP_H_TOTAL (H),
    .EXP_H_ACTIVE(HA),
    .EXP_V_TOTAL (V),
    .EXP_V_ACTIVE(VA),
    .TIMEOUT     (TO)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .pixel_en  (pixel_en),
    .hsync     (hsync),
    .vsync     (vsync),
    .blanking  (blanking),
    .colores   (colores),
    .h_total   (h_total),
    .h_active  (h_active),
    .v_total   (v_total),
    .v_active  (v_active),
    .frame_sum (frame_sum),
    .frame_done(frame_done),
    .locked    (locked),
    .timing_err(timing_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // nl lines; last na lines carry npx active pixels; vsync low at voff
  task automatic add_frame(input int nl, input int na, input int npx,
                           input int long_idx, input int long_len,
                           input int voff, input int mode);
    tick_t k;
    int    len;
    for (int l = 0; l < nl; l++) begin
      len = (l == long_idx) ? long_len : H;
      for (int i = 0; i < len; i++) begin
        k.hs = (i != 0);
        k.vs = !(l == 0 && i == voff);
        k.bl = !(l >= nl - na && i >= 1 && i <= npx);
        if (k.bl || mode == 0) k.col = 8'($urandom);
        else if (mode == 1)    k.col = 8'h01;
        else                   k.col = 8'hFF;
        stim.push_back(k);
      end
    end
  endtask

  function automatic int count_act(input int a, input int b);
    int c;
    c = 0;
    for (int i = a; i < b; i++) if (!stim[i].bl) c++;
    return c;
  endfunction

  // reference: lines are spans between hsync falls, frames between vsync falls
  task automatic run_model(input int n);
    int   hq[$];
    int   last_h, prev_v, st, mc, ht, ha, vt, va, fs, s, lst;
    bit   ph, pv, he, ve, to, match, bad;
    exp_t e;
    last_h = 0; prev_v = -1; st = 0; mc = 0;
    ht = 0; ha = 0; vt = 0; va = 0; fs = 0;
    ph = 1; pv = 1;
    for (int t = 0; t < n; t++) begin
      he = ph && !stim[t].hs;
      ve = pv && !stim[t].vs;
      ph = stim[t].hs;
      pv = stim[t].vs;
      to = !he && (t - last_h + 1 == TO);
      bad = he && (t - last_h != H);
      if (he) begin
        ht = t - last_h;
        ha = count_act(last_h, t);
        hq.push_back(t);
        last_h = t;
      end
      if (ve) begin
        vt = 0; va = 0; s = 0;
        foreach (hq[j]) begin
          lst = (j == 0) ? 0 : hq[j-1];
          if (hq[j] >= prev_v && hq[j] < t) vt++;
          if (hq[j] > prev_v && count_act(lst, hq[j]) > 0) va++;
        end
        for (int i = (prev_v < 0 ? 0 : prev_v); i < t; i++)
          if (!stim[i].bl) s += int'(stim[i].col);
        fs = s % 65536;
`ifndef VGA_MON_CHECKSUM_EN
        fs = 0;
`endif
        prev_v = t;
      end
      match = (ht == H) && (ha == HA) && (vt == V) && (va == VA);
      e = '{default: 0};
      if (to) begin
        e.err = 1; st = 0; mc = 0;
      end else if (st == 0) begin
        if (ve) begin st = 1; mc = 0; end
      end else if (st == 1) begin
        if (ve) begin
          e.done = 1;
          if (match) begin
            mc++;
            if (mc == 2) st = 2;
          end else begin
            e.err = 1; mc = 0;
          end
        end
      end else begin
        if (ve) e.done = 1;
        if (bad || (ve && !match)) begin
          e.err = 1; st = 1; mc = 0;
        end
      end
      if (e.done || e.err) begin
        e.lk = (st == 2);
        e.ht = ht; e.ha = ha; e.vt = vt; e.va = va; e.fs = fs;
        sbq.push_back(e);
      end
    end
    model_lk = (st == 2);
  endtask

  task automatic drive(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      hsync    = stim[i].hs;
      vsync    = stim[i].vs;
      blanking = stim[i].bl;
      colores  = stim[i].col;
      pixel_en = 1'b1;
      @(negedge clock);
      pixel_en = 1'b0;
      repeat (2) @(negedge clock);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_h_total"}, int'(h_total), 0);
    chk({tag, "_h_active"}, int'(h_active), 0);
    chk({tag, "_v_total"}, int'(v_total), 0);
    chk({tag, "_v_active"}, int'(v_active), 0);
    chk({tag, "_frame_sum"}, int'(frame_sum), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_timing_err"}, int'(timing_err), 0);
  endtask

  task automatic nominal(input int cnt);
    for (int f = 0; f < cnt; f++)
      add_frame(V, VA, HA, -1, H, int'($urandom_range(1, 9)), 0);
  endtask

  // scoreboard monitor: pops one expectation per pulse
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (reset_n && (frame_done || timing_err)) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: done=%0b err=%0b expected none",
                 frame_done, timing_err);
      end else begin
        e = sbq.pop_front();
        chk("frame_done", int'(frame_done), int'(e.done));
        chk("timing_err", int'(timing_err), int'(e.err));
        chk("locked", int'(locked), int'(e.lk));
        if (e.done) begin
          chk("h_total", int'(h_total), e.ht);
          chk("h_active", int'(h_active), e.ha);
          chk("v_total", int'(v_total), e.vt);
          chk("v_active", int'(v_active), e.va);
          chk("frame_sum", int'(frame_sum), e.fs);
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clock);
    chk_zero("reset");
    reset_n = 1'b1;

    // lock, line error, timeout, coincident edges, wrap
    for (int f = 0; f < 4; f++) add_frame(V, VA, HA, -1, H, 3, 1);
    nominal(2);
    add_frame(V, VA, HA, 2, 11, int'($urandom_range(1, 9)), 0);
    nominal(3);
    add_frame(V, VA, HA, 2, 40, int'($urandom_range(1, 9)), 0);
    nominal(3);
    for (int f = 0; f < 5; f++) add_frame(V, VA, HA, -1, H, 0, 0);
    add_frame(V, VA, 5, -1, H, int'($urandom_range(1, 9)), 0);
    add_frame(60, 59, HA, -1, H, 3, 2);
    nominal(2);
    run_model(stim.size());
    drive(stim.size());
    repeat (8) @(negedge clock);
    chk("seg_a_queue_empty", sbq.size(), 0);

    // reset in the middle of a line
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    stim.delete();
    nominal(4);
    n = stim.size() - 25;
    run_model(n);
    drive(n);
    repeat (4) @(negedge clock);
    chk("seg_b_queue_empty", sbq.size(), 0);
    chk("locked_before_reset", int'(locked), int'(model_lk));
    #2 reset_n = 1'b0;
    #1 chk_zero("async_reset");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // restart after reset: first vedge gives no frame_done
    stim.delete();
    nominal(4);
    run_model(stim.size());
    drive(stim.size());
    repeat (8) @(negedge clock);
    chk("seg_c_queue_empty", sbq.size(), 0);
    chk("seg_c_locked", int'(locked), int'(model_lk));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
